load_store_unit: RTL and testbench

//  MEM-stage load/store unit between the pipeline and data_memory. Accepts one load/store per

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_lane_align.sv | 55 +++++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: opcode field layout, size codes,
// FSM state encoding and request-legality helpers.
package lsu_pkg;

    localparam int OP_STORE_BIT    = 3;
    localparam int OP_UNSIGNED_BIT = 2;

    localparam logic [1:0] SIZE_B       = 2'b00;
    localparam logic [1:0] SIZE_H       = 2'b01;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b10;
    localparam logic [1:0] SIZE_W       = 2'b11;

    localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'h1000_1000;
    localparam int          DEFAULT_DEPTH_WORDS = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_e;

    function automatic logic op_is_illegal(input logic [3:0] op);
        return (op[1:0] == SIZE_ILLEGAL) || (op[OP_STORE_BIT] && op[OP_UNSIGNED_BIT]);
    endfunction

    function automatic logic addr_is_misaligned(input logic [1:0] size, input logic [1:0] low_addr);
        return ((size == SIZE_H) && low_addr[0]) || ((size == SIZE_W) && (low_addr != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian byte/halfword lane handling: extracts and extends load data and
// merges sub-word store data into the previously read word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] ld_data,
    input  logic [31:0] st_old_word,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_merged
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [31:0] byte_word;
    logic [31:0] half_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Offset 0 lives in the most significant lane, so the shift is (3 - offset) lanes.
    always_comb begin
        byte_shift = {~offset, 3'b000};
        half_shift = {~offset[1], 4'b0000};
        byte_word  = ld_word >> byte_shift;
        half_word  = ld_word >> half_shift;
        ld_byte    = byte_word[7:0];
        ld_half    = half_word[15:0];
    end

    always_comb begin
        ld_data = '0;
        case (size)
            SIZE_B:  ld_data = is_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SIZE_H:  ld_data = is_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            SIZE_W:  ld_data = ld_word;
            default: ld_data = '0;
        endcase
    end

    always_comb begin
        st_merged = st_old_word;
        case (size)
            SIZE_B: st_merged = (st_old_word & ~(32'h0000_00FF << byte_shift))
                              | (32'(st_wdata[7:0]) << byte_shift);
            SIZE_H: st_merged = (st_old_word & ~(32'h0000_FFFF << half_shift))
                              | (32'(st_wdata[15:0]) << half_shift);
            SIZE_W: st_merged = st_wdata;
            default: st_merged = st_old_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one request per handshake, word-wide accesses to
// data_memory, read-modify-write for sub-word stores, error rejection up front.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

    lsu_state_e  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        accept;
    logic        req_store;
    logic        req_illegal;
    logic        req_misaligned;
    logic        req_range_err;
    logic        req_err;
    logic        op_store;
    logic [31:0] ld_data;
    logic [31:0] st_merged;

    assign accept   = req_valid && (state_q == ST_IDLE);
    assign op_store = op_q[OP_STORE_BIT];

    // Range check is done in 33 bits so the top of the window cannot wrap.
    always_comb begin
        req_store      = req_op[OP_STORE_BIT];
        req_illegal    = op_is_illegal(req_op);
        req_misaligned = addr_is_misaligned(req_op[1:0], req_addr[1:0]);
        req_range_err  = ({1'b0, req_addr} < {1'b0, BASE_ADDR}) || ({1'b0, req_addr} >= END_ADDR);
        req_err        = req_illegal || req_misaligned || req_range_err;
    end

    lsu_lane_align u_lane_align (
        .ld_word     (mem_read_data),
        .offset      (addr_q[1:0]),
        .size        (op_q[1:0]),
        .is_unsigned (op_q[OP_UNSIGNED_BIT]),
        .ld_data     (ld_data),
        .st_old_word (mem_read_data),
        .st_wdata    (wdata_q),
        .st_merged   (st_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (req_store && (req_op[1:0] == SIZE_W)) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD:   state_d = ST_CAP;
            ST_CAP:  state_d = ST_RESP;
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Response registers are only updated on the edge entering RESP, so they hold between responses.
    always_comb begin
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (accept) begin
            op_d    = req_op;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            if (req_err) begin
                resp_rdata_d = '0;
                resp_err_d   = 1'b1;
            end
        end
        if (state_q == ST_CAP) begin
            resp_rdata_d = op_store ? '0 : ld_data;
            resp_err_d   = 1'b0;
        end
        if (state_q == ST_WR) begin
            resp_rdata_d = '0;
            resp_err_d   = 1'b0;
        end
    end

    always_comb begin
        req_ready      = (state_q == ST_IDLE);
        resp_valid     = (state_q == ST_RESP);
        mem_read       = (state_q == ST_RD);
        mem_write      = (state_q == ST_WR) || ((state_q == ST_CAP) && op_store);
        mem_address    = {addr_q[31:2], 2'b00};
        mem_write_data = '0;
        if (state_q == ST_WR) begin
            mem_write_data = wdata_q;
        end else if ((state_q == ST_CAP) && op_store) begin
            mem_write_data = st_merged;
        end
        resp_rdata     = resp_rdata_q;
        resp_err       = resp_err_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural word memory
// standing in for data_memory, table-driven vectors and a response scoreboard.
module tb_load_store_unit;

   localparam logic [31:0] BASE = 32'h1000_1000;

   localparam logic [3:0] OP_LB  = 4'b0000;
   localparam logic [3:0] OP_LH  = 4'b0001;
   localparam logic [3:0] OP_LW  = 4'b0011;
   localparam logic [3:0] OP_LBU = 4'b0100;
   localparam logic [3:0] OP_LHU = 4'b0101;
   localparam logic [3:0] OP_SB  = 4'b1000;
   localparam logic [3:0] OP_SH  = 4'b1001;
   localparam logic [3:0] OP_SW  = 4'b1011;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expRdata;
      logic        expErr;
      int          expLat;
      string       name;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_read_data;

   int checks = 0;
   int failures = 0;
   int acceptCnt = 0;
   vec_t vecs[$];
   exp_t expQ[$];

   // Free-running 10-time-unit clock
   always #5 clk = ~clk;

   load_store_unit #(
      .BASE_ADDR   (BASE),
      .DEPTH_WORDS (16)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_op         (req_op),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_read_data  (mem_read_data)
   );

   // Behavioural data_memory: synchronous write, read data registered on the read edge
   logic [31:0] mem [16];
   logic        memClear;
   logic [31:0] memOffset;
   assign memOffset = mem_address - BASE;

   always @(posedge clk) begin
      if (memClear) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
         mem_read_data <= '0;
      end else begin
         if (mem_write) mem[memOffset[5:2]] <= mem_write_data;
         if (mem_read) mem_read_data <= mem[memOffset[5:2]];
      end
   end

   // Count every handshake so back-to-back traffic can be checked for single acceptance
   always @(posedge clk) begin
      if (req_valid && req_ready) acceptCnt <= acceptCnt + 1;
   end

   // Generic comparison used by every check in the bench
   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, expv);
      end
   endtask

   // Pop the oldest expected response and compare it with what the DUT produced
   task automatic checkOutput(input logic [31:0] rdata, input logic err, input int lat, input logic strobeSeen);
      exp_t e;
      if (expQ.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL unexpected_response actual=%h required=none", rdata);
         return;
      end
      e = expQ.pop_front();
      checkValue({e.name, " rdata"}, rdata, e.rdata);
      checkValue({e.name, " err"}, 32'(err), 32'(e.err));
      checkValue({e.name, " latency"}, lat, e.lat);
      if (e.err) checkValue({e.name, " no_strobe"}, 32'(strobeSeen), 32'd0);
   endtask

   // Drive one request from an idle negedge, wait (bounded) for its response and score it
   task automatic applyStimulus(input vec_t v);
      int lat;
      logic strobeSeen;
      @(negedge clk);
      if (!req_ready) begin
         checkValue({v.name, " ready_before"}, 32'(req_ready), 32'd1);
         return;
      end
      req_op    = v.op;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_valid = 1'b1;
      expQ.push_back('{v.expRdata, v.expErr, v.expLat, v.name});
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      strobeSeen = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         strobeSeen = strobeSeen | mem_read | mem_write;
      end while (!resp_valid && lat < 12);
      if (!resp_valid) begin
         void'(expQ.pop_front());
         checkValue({v.name, " response_timeout"}, 32'(resp_valid), 32'd1);
         return;
      end
      checkOutput(resp_rdata, resp_err, lat, strobeSeen);
      @(negedge clk);
      checkValue({v.name, " one_cycle_pulse"}, 32'(resp_valid), 32'd0);
   endtask

   task automatic addVec(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] expRdata, input logic expErr, input int expLat, input string name);
      vecs.push_back('{op, addr, wdata, expRdata, expErr, expLat, name});
   endtask

   initial begin
      int lat;
      int acceptBase;
      logic readySeen;
      logic pulseSeen;

      rst_n     = 1'b0;
      memClear  = 1'b1;
      req_valid = 1'b0;
      req_op    = '0;
      req_addr  = '0;
      req_wdata = '0;

      // Reset values while reset is held
      repeat (2) @(negedge clk);
      checkValue("reset req_ready", 32'(req_ready), 32'd1);
      checkValue("reset resp_valid", 32'(resp_valid), 32'd0);
      checkValue("reset resp_rdata", resp_rdata, 32'd0);
      checkValue("reset resp_err", 32'(resp_err), 32'd0);
      checkValue("reset mem_read", 32'(mem_read), 32'd0);
      checkValue("reset mem_write", 32'(mem_write), 32'd0);
      checkValue("reset mem_address", mem_address, 32'd0);
      checkValue("reset mem_write_data", mem_write_data, 32'd0);
      rst_n    = 1'b1;
      memClear = 1'b0;

      // Vector table: functional accesses, extension cases, boundaries and every error class
      addVec(OP_SW,  32'h1000_1000, 32'h1122_3344, 32'h0000_0000, 1'b0, 2, "sw_word0");
      addVec(OP_LW,  32'h1000_1000, 32'h0,         32'h1122_3344, 1'b0, 3, "lw_word0");
      addVec(OP_SB,  32'h1000_1001, 32'hFFFF_FFAA, 32'h0000_0000, 1'b0, 3, "sb_off1");
      addVec(OP_LW,  32'h1000_1000, 32'h0,         32'h11AA_3344, 1'b0, 3, "lw_after_sb");
      addVec(OP_LB,  32'h1000_1001, 32'h0,         32'hFFFF_FFAA, 1'b0, 3, "lb_off1");
      addVec(OP_LBU, 32'h1000_1001, 32'h0,         32'h0000_00AA, 1'b0, 3, "lbu_off1");
      addVec(OP_LB,  32'h1000_1000, 32'h0,         32'h0000_0011, 1'b0, 3, "lb_off0");
      addVec(OP_LB,  32'h1000_1003, 32'h0,         32'h0000_0044, 1'b0, 3, "lb_off3");
      addVec(OP_SH,  32'h1000_1006, 32'h1234_8001, 32'h0000_0000, 1'b0, 3, "sh_off2");
      addVec(OP_LW,  32'h1000_1004, 32'h0,         32'h0000_8001, 1'b0, 3, "lw_after_sh");
      addVec(OP_LH,  32'h1000_1006, 32'h0,         32'hFFFF_8001, 1'b0, 3, "lh_off2");
      addVec(OP_LHU, 32'h1000_1006, 32'h0,         32'h0000_8001, 1'b0, 3, "lhu_off2");
      addVec(OP_LHU, 32'h1000_1004, 32'h0,         32'h0000_0000, 1'b0, 3, "lhu_off0");
      addVec(OP_SW,  32'h1000_103C, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, "sw_last_word");
      addVec(OP_LW,  32'h1000_103C, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, "lw_last_word");
      addVec(OP_LW,  32'h1000_1002, 32'h0,         32'h0000_0000, 1'b1, 1, "err_lw_misaligned");
      addVec(OP_SH,  32'h1000_1003, 32'h0,         32'h0000_0000, 1'b1, 1, "err_sh_misaligned");
      addVec(OP_LW,  32'h1000_1040, 32'h0,         32'h0000_0000, 1'b1, 1, "err_above_range");
      addVec(OP_LW,  32'h1000_0FFC, 32'h0,         32'h0000_0000, 1'b1, 1, "err_below_range");
      addVec(4'b0010, 32'h1000_1000, 32'h0,        32'h0000_0000, 1'b1, 1, "err_size10");
      addVec(4'b1100, 32'h1000_1000, 32'h0,        32'h0000_0000, 1'b1, 1, "err_unsigned_store");
      addVec(OP_LW,  32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1'b1, 1, "err_top_of_space");
      addVec(OP_LW,  32'h1000_1000, 32'h0,         32'h11AA_3344, 1'b0, 3, "lw_after_errors");
      addVec(OP_SW,  32'h1000_1008, 32'hCAFE_BABE, 32'h0000_0000, 1'b0, 2, "sw_word2");

      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

      // Reset asserted in the CAP cycle of an SB: strobes drop at once, write never lands
      @(negedge clk);
      req_op    = OP_SB;
      req_addr  = 32'h1000_1008;
      req_wdata = 32'h0000_0055;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      checkValue("abort rd_strobe", 32'(mem_read), 32'd1);
      @(negedge clk);
      checkValue("abort cap_write_strobe", 32'(mem_write), 32'd1);
      rst_n = 1'b0;
      #1;
      checkValue("abort write_dropped", 32'(mem_write), 32'd0);
      checkValue("abort read_dropped", 32'(mem_read), 32'd0);
      checkValue("abort resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pulseSeen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         pulseSeen = pulseSeen | resp_valid;
      end
      checkValue("abort no_response", 32'(pulseSeen), 32'd0);
      checkValue("abort ready_after", 32'(req_ready), 32'd1);
      applyStimulus('{OP_LW, 32'h1000_1008, 32'h0, 32'hCAFE_BABE, 1'b0, 3, "abort word_unchanged"});

      // req_valid held high across back-to-back SW then LW
      @(negedge clk);
      acceptBase = acceptCnt;
      req_op    = OP_SW;
      req_addr  = 32'h1000_100C;
      req_wdata = 32'h0BAD_F00D;
      req_valid = 1'b1;
      expQ.push_back('{32'h0, 1'b0, 2, "b2b_sw"});
      @(posedge clk);
      lat = 0;
      readySeen = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         readySeen = readySeen | req_ready;
      end while (!resp_valid && lat < 12);
      checkOutput(resp_rdata, resp_err, lat, 1'b0);
      checkValue("b2b_sw ready_low", 32'(readySeen), 32'd0);
      checkValue("b2b_sw accepts", acceptCnt - acceptBase, 32'd1);
      req_op = OP_LW;
      expQ.push_back('{32'h0BAD_F00D, 1'b0, 3, "b2b_lw"});
      @(negedge clk);
      checkValue("b2b idle_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      lat = 0;
      readySeen = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         readySeen = readySeen | req_ready;
      end while (!resp_valid && lat < 12);
      checkOutput(resp_rdata, resp_err, lat, 1'b0);
      checkValue("b2b_lw ready_low", 32'(readySeen), 32'd0);
      checkValue("b2b_lw accepts", acceptCnt - acceptBase, 32'd2);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
